// File: rtl/sap2_pkg.sv
// SAP-2 control sequencer: control-word bit map, opcodes, states.
// Shared by the sequencer and anything that decodes its strobes.
package sap2_pkg;

    localparam int CON_W   = 30;
    localparam int CON_EP  = 0;
    localparam int CON_LP  = 1;
    localparam int CON_CP  = 2;
    localparam int CON_ES  = 3;
    localparam int CON_LS  = 4;
    localparam int CON_CS  = 5;
    localparam int CON_LM  = 6;
    localparam int CON_CE  = 7;
    localparam int CON_WE  = 8;
    localparam int CON_LI  = 9;
    localparam int CON_EI  = 10;
    localparam int CON_LA  = 11;
    localparam int CON_EA  = 12;
    localparam int CON_LB  = 13;
    localparam int CON_EU  = 14;
    localparam int CON_S0  = 15;
    localparam int CON_M   = 19;
    localparam int CON_CI  = 20;
    localparam int CON_LX  = 21;
    localparam int CON_INX = 22;
    localparam int CON_DEX = 23;
    localparam int CON_EX  = 24;
    localparam int CON_EN  = 25;
    localparam int CON_LN  = 26;
    localparam int CON_LO  = 27;
    localparam int CON_HLT = 28;

    localparam logic [3:0] OP_LDA  = 4'h0;
    localparam logic [3:0] OP_STA  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JAM  = 4'h5;
    localparam logic [3:0] OP_JAZ  = 4'h6;
    localparam logic [3:0] OP_JXM  = 4'h7;
    localparam logic [3:0] OP_JXZ  = 4'h8;
    localparam logic [3:0] OP_CALL = 4'h9;
    localparam logic [3:0] OP_RET  = 4'hA;
    localparam logic [3:0] OP_LDX  = 4'hB;
    localparam logic [3:0] OP_INX  = 4'hC;
    localparam logic [3:0] OP_DEX  = 4'hD;
    localparam logic [3:0] OP_IO   = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'b1001;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        S_T1   = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_T6   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    // Number of execute steps (T4 onward) an opcode occupies.
    function automatic logic [1:0] exec_len(input logic [3:0] op);
        logic [1:0] n;
        n = 2'd1;
        if (op == OP_LDA || op == OP_STA || op == OP_CALL || op == OP_LDX)
            n = 2'd2;
        else if (op == OP_ADD || op == OP_SUB)
            n = 2'd3;
        return n;
    endfunction

endpackage

// File: rtl/sap2_ctrl.sv
// SAP-2 control sequencer: T-state ring with variable-length execute,
// combinational control-word decode, halt and programming-mode hold.
module sap2_ctrl
    import sap2_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             prog,
    input  logic [7:0]       ins,
    input  logic             am,
    input  logic             az,
    input  logic             xm,
    input  logic             xz,
    output logic [CON_W-1:0] con,
    output logic [5:0]       t,
    output logic             halted
);

    state_t           state;
    state_t           nxt;
    logic [3:0]       op;
    logic [1:0]       len;
    logic [CON_W-1:0] c;
    logic             unused_func;

    assign op          = ins[7:4];
    assign len         = exec_len(op);
    assign unused_func = ^ins[3:1];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_T1;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_T1: nxt = S_T2;
            S_T2: nxt = S_T3;
            S_T3: nxt = S_T4;
            S_T4: begin
                if (op == OP_HLT)   nxt = S_HALT;
                else if (len == 1)  nxt = S_T1;
                else                nxt = S_T5;
            end
            S_T5: nxt = (len == 2) ? S_T1 : S_T6;
            S_T6: nxt = S_T1;
            default: nxt = S_HALT;
        endcase
        if (prog && state != S_HALT)
            nxt = S_T1;
    end

    always_comb begin
        c = '0;
        unique case (state)
            S_T1: begin
                c[CON_EP] = 1'b1;
                c[CON_LM] = 1'b1;
            end
            S_T2: c[CON_CP] = 1'b1;
            S_T3: begin
                c[CON_CE] = 1'b1;
                c[CON_LI] = 1'b1;
            end
            S_T4: begin
                unique case (op)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_LDX: begin
                        c[CON_EI] = 1'b1;
                        c[CON_LM] = 1'b1;
                    end
                    OP_JMP: begin
                        c[CON_EI] = 1'b1;
                        c[CON_LP] = 1'b1;
                    end
                    OP_JAM, OP_JAZ, OP_JXM, OP_JXZ: begin
                        c[CON_EI] = 1'b1;
                        unique case (op)
                            OP_JAM:  c[CON_LP] = am;
                            OP_JAZ:  c[CON_LP] = az;
                            OP_JXM:  c[CON_LP] = xm;
                            default: c[CON_LP] = xz;
                        endcase
                    end
                    OP_CALL: begin
                        c[CON_EP] = 1'b1;
                        c[CON_LS] = 1'b1;
                    end
                    OP_RET: begin
                        c[CON_ES] = 1'b1;
                        c[CON_LP] = 1'b1;
                    end
                    OP_INX: c[CON_INX] = 1'b1;
                    OP_DEX: c[CON_DEX] = 1'b1;
                    OP_IO: begin
                        if (ins[0]) begin
                            c[CON_EA] = 1'b1;
                            c[CON_LO] = 1'b1;
                        end else begin
                            c[CON_EN] = 1'b1;
                            c[CON_LA] = 1'b1;
                        end
                    end
                    default: c[CON_HLT] = 1'b1;
                endcase
            end
            S_T5: begin
                unique case (op)
                    OP_LDA: begin
                        c[CON_CE] = 1'b1;
                        c[CON_LA] = 1'b1;
                    end
                    OP_STA: begin
                        c[CON_EA] = 1'b1;
                        c[CON_WE] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        c[CON_CE] = 1'b1;
                        c[CON_LB] = 1'b1;
                    end
                    OP_CALL: begin
                        c[CON_EI] = 1'b1;
                        c[CON_LP] = 1'b1;
                    end
                    OP_LDX: begin
                        c[CON_CE] = 1'b1;
                        c[CON_LX] = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            S_T6: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    c[CON_EU] = 1'b1;
                    c[CON_LA] = 1'b1;
                    c[CON_S0 +: 4] = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
                    c[CON_M]  = 1'b0;
                    c[CON_CI] = (op == OP_SUB);
                end
            end
            default: c = '0;
        endcase
    end

    // Reset and programming hold blank the strobes without waiting for an edge.
    assign con    = (clr_n && !prog) ? c : '0;
    assign halted = (state == S_HALT);

    always_comb begin
        t = '0;
        unique case (state)
            S_T1: t[0] = 1'b1;
            S_T2: t[1] = 1'b1;
            S_T3: t[2] = 1'b1;
            S_T4: t[3] = 1'b1;
            S_T5: t[4] = 1'b1;
            S_T6: t[5] = 1'b1;
            default: t = '0;
        endcase
    end

endmodule

// File: tb/tb_sap2_ctrl.sv
// Directed bench for the SAP-2 control sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_sap2_ctrl;

    logic        clk;
    logic        clr_n;
    logic        prog;
    logic [7:0]  ins;
    logic        am;
    logic        az;
    logic        xm;
    logic        xz;
    logic [29:0] con;
    logic [5:0]  t;
    logic        halted;

    int n_chk;
    int n_pass;

    sap2_ctrl dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .prog   (prog),
        .ins    (ins),
        .am     (am),
        .az     (az),
        .xm     (xm),
        .xz     (xz),
        .con    (con),
        .t      (t),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Runs one instruction from a T1 falling edge back to the next T1.
    task automatic run(input string tag, input logic [7:0] op,
                       input int n, input logic [29:0] e4,
                       input logic [29:0] e5, input logic [29:0] e6);
        chk({tag, "_t1"}, {2'b0, con}, 32'h041);
        chk({tag, "_t1s"}, {26'b0, t}, 32'h01);
        @(negedge clk);
        chk({tag, "_t2"}, {2'b0, con}, 32'h004);
        @(negedge clk);
        chk({tag, "_t3"}, {2'b0, con}, 32'h280);
        ins = op;
        @(negedge clk);
        #1;
        chk({tag, "_t4"}, {2'b0, con}, {2'b0, e4});
        chk({tag, "_t4s"}, {26'b0, t}, 32'h08);
        if (n >= 5) begin
            @(negedge clk);
            chk({tag, "_t5"}, {2'b0, con}, {2'b0, e5});
        end
        if (n >= 6) begin
            @(negedge clk);
            chk({tag, "_t6"}, {2'b0, con}, {2'b0, e6});
        end
        @(negedge clk);
        chk({tag, "_end"}, {26'b0, t}, 32'h01);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        clr_n  = 1'b0;
        prog   = 1'b0;
        ins    = 8'h00;
        am     = 1'b0;
        az     = 1'b0;
        xm     = 1'b0;
        xz     = 1'b0;
        #3;
        chk("rst_con", {2'b0, con}, 32'h0);
        chk("rst_t", {26'b0, t}, 32'h01);
        chk("rst_halt", {31'b0, halted}, 32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        #1;

        run("add",  8'h20, 6, 30'h440, 30'h2080, 30'h4C800);
        run("sub",  8'h30, 6, 30'h440, 30'h2080, 30'h134800);
        run("lda",  8'h00, 5, 30'h440, 30'h880, 30'h0);
        run("sta",  8'h10, 5, 30'h440, 30'h1100, 30'h0);
        az = 1'b1;
        run("jaz1", 8'h60, 4, 30'h402, 30'h0, 30'h0);
        az = 1'b0;
        run("jaz0", 8'h60, 4, 30'h400, 30'h0, 30'h0);
        run("jam0", 8'h50, 4, 30'h400, 30'h0, 30'h0);
        xm = 1'b1;
        run("jxm1", 8'h70, 4, 30'h402, 30'h0, 30'h0);
        xm = 1'b0;
        xz = 1'b1;
        run("jxz1", 8'h80, 4, 30'h402, 30'h0, 30'h0);
        xz = 1'b0;
        run("jmp",  8'h40, 4, 30'h402, 30'h0, 30'h0);
        run("call", 8'h90, 5, 30'h011, 30'h402, 30'h0);
        run("ret",  8'hA0, 4, 30'h00A, 30'h0, 30'h0);
        run("ldx",  8'hB0, 5, 30'h440, 30'h200080, 30'h0);
        run("inx",  8'hC0, 4, 30'h400000, 30'h0, 30'h0);
        run("dex",  8'hD0, 4, 30'h800000, 30'h0, 30'h0);
        run("in",   8'hE0, 4, 30'h2000800, 30'h0, 30'h0);
        run("out",  8'hE1, 4, 30'h8001000, 30'h0, 30'h0);

        // Programming mode holds at T1 with no strobes.
        prog = 1'b1;
        #1;
        chk("prog_con0", {2'b0, con}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("prog_con", {2'b0, con}, 32'h0);
            chk("prog_t", {26'b0, t}, 32'h01);
        end
        prog = 1'b0;
        #1;
        chk("prog_rel", {2'b0, con}, 32'h041);
        @(negedge clk);
        chk("prog_t2", {26'b0, t}, 32'h02);
        @(negedge clk);
        ins = 8'h20;
        @(negedge clk);
        @(negedge clk);
        chk("mid_t5", {2'b0, con}, 32'h2080);

        // Asynchronous reset in the middle of ADD T5.
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst_con", {2'b0, con}, 32'h0);
        chk("arst_t", {26'b0, t}, 32'h01);
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        chk("arst_t1", {2'b0, con}, 32'h041);
        @(negedge clk);
        chk("arst_t2", {2'b0, con}, 32'h004);
        chk("arst_t2s", {26'b0, t}, 32'h02);
        @(negedge clk);
        ins = 8'hF0;
        @(negedge clk);
        #1;
        chk("hlt_t4", {2'b0, con}, 32'h10000000);
        chk("hlt_pre", {31'b0, halted}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_con", {2'b0, con}, 32'h0);
            chk("halt_flag", {31'b0, halted}, 32'h1);
            chk("halt_t", {26'b0, t}, 32'h0);
            prog = i[0];
        end
        prog = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        chk("hrst_flag", {31'b0, halted}, 32'h0);
        chk("hrst_t", {26'b0, t}, 32'h01);
        chk("hrst_con", {2'b0, con}, 32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        chk("hrst_t2", {26'b0, t}, 32'h02);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
